// File: rtl/regbank_pkg.sv
// Shared types for the register-bank write path: entry layout, issue FSM
// states and the address-to-busy-bit decode.
package regbank_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2
    } wb_state_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regbank_write_scheduler_fifo.sv
// Writeback FIFO with two prioritised push ports and a single pop. Exposes the
// head plus per-slot valid/address so the top can build the pending mask.
module wb_fifo
    import regbank_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push0_i,
    input  wb_entry_t                      push0_entry_i,
    input  logic                           push1_i,
    input  wb_entry_t                      push1_entry_i,
    input  logic                           pop_i,
    output wb_entry_t                      head_o,
    output logic [CW-1:0]                  count_o,
    output logic [DEPTH-1:0]               valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]   addr_o
);

    wb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   slot1;

    // The second port lands behind the first when both push together.
    assign slot1    = wr_ptr_q + PW'(push0_i);
    assign wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
    assign rd_ptr_d = rd_ptr_q + PW'(pop_i);
    assign count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);

    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wr_ptr_q] <= push0_entry_i;
        if (push1_i) mem_q[slot1]    <= push1_entry_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] offset;
            assign offset      = PW'(gi) - rd_ptr_q;
            assign valid_o[gi] = ({1'b0, offset} < count_q);
            assign addr_o[gi]  = mem_q[gi].addr;
        end
    endgenerate

endmodule

// File: rtl/regbank_write_scheduler.sv
// Write-side front end of the 16x32 register bank: queues ES/DS writebacks and
// replays each as an address/data setup cycle followed by a one-cycle strobe.
module regbank_write_scheduler #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 4,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              es_req,
    input  logic [ADDR_W-1:0] es_addr,
    input  logic [DATA_W-1:0] es_data,
    output logic              es_ready,
    input  logic              ds_req,
    input  logic [ADDR_W-1:0] ds_addr,
    input  logic [DATA_W-1:0] ds_data,
    output logic              ds_ready,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [15:0]       busy_mask,
    output logic [CW-1:0]     count
);

    import regbank_pkg::*;

    wb_state_t                         state_q, state_d;
    logic                              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]                 wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]                 wr_data_q, wr_data_d;
    logic                              es_push, ds_push, pop;
    wb_entry_t                         head;
    logic [CW-1:0]                     fifo_count;
    logic [DEPTH-1:0]                  slot_valid;
    logic [DEPTH-1:0][ADDR_W-1:0]      slot_addr;

    // With one slot left, ES (the older instruction) takes it.
    assign es_ready = (fifo_count < CW'(DEPTH));
    assign ds_ready = es_ready && !(es_req && (fifo_count == CW'(DEPTH - 1)));
    assign es_push  = es_req && es_ready;
    assign ds_push  = ds_req && ds_ready;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push0_i       (es_push),
        .push0_entry_i ('{addr: es_addr, data: es_data}),
        .push1_i       (ds_push),
        .push1_entry_i ('{addr: ds_addr, data: ds_data}),
        .pop_i         (pop),
        .head_o        (head),
        .count_o       (fifo_count),
        .valid_o       (slot_valid),
        .addr_o        (slot_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_count != '0) state_d = SETUP;
            SETUP:   state_d = PULSE;
            PULSE:   state_d = (fifo_count != '0) ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address/data only reload on entry to SETUP, so they are steady while strobe is high.
    always_comb begin
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        pop         = 1'b0;
        case (state_q)
            IDLE, PULSE: begin
                if (fifo_count != '0) begin
                    wr_addr_d = head.addr;
                    wr_data_d = head.data;
                end
            end
            SETUP: begin
                wr_strobe_d = 1'b1;
                pop         = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) busy_mask = busy_mask | addr_onehot(slot_addr[i]);
        end
        if (state_q != IDLE) busy_mask = busy_mask | addr_onehot(wr_addr_q);
    end

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign count     = fifo_count;

endmodule

// File: tb/tb_regbank_write_scheduler.sv
// Scoreboard bench for regbank_write_scheduler: accepted writes are queued and
// matched against each bank strobe; occupancy, readies and busy mask are modelled.
module tb_regbank_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        es_req, ds_req;
    logic [3:0]  es_addr, ds_addr;
    logic [31:0] es_data, ds_data;
    logic        es_ready, ds_ready;
    logic        wr_strobe;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] busy_mask;
    logic [2:0]  count;

    regbank_write_scheduler #(.DEPTH(4), .DATA_W(32), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .es_req    (es_req),
        .es_addr   (es_addr),
        .es_data   (es_data),
        .es_ready  (es_ready),
        .ds_req    (ds_req),
        .ds_addr   (ds_addr),
        .ds_data   (ds_data),
        .ds_ready  (ds_ready),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_mask (busy_mask),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } txn_t;

    txn_t        sb[$];
    int          rise_cyc[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rises = 0;
    int          r1_strobes = 0;
    int          saw_full = 0;
    int          saw_es_only = 0;
    logic        prev_strobe = 1'b0;
    logic [3:0]  held_addr = '0;
    logic [31:0] bank [16];
    logic [31:0] exp_bank [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Negedge monitor: strobes retire scoreboard entries, accepts push new ones.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_strobe = 1'b0;
        end else begin
            logic [15:0] exp_busy;
            cyc++;
            check("strobe_width", 32'(wr_strobe & prev_strobe), 32'd0);
            if (wr_strobe && !prev_strobe) begin
                rises++;
                rise_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    txn_t t;
                    t = sb.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(t.a));
                    check("wr_data", wr_data, t.d);
                end
                bank[wr_addr] = wr_data;
                if (wr_addr == 4'd1) r1_strobes++;
                held_addr = wr_addr;
                $display("WR t=%0t r%0d <= 0x%08h", $time, wr_addr, wr_data);
            end
            prev_strobe = wr_strobe;

            check("count", 32'(count), 32'(sb.size()));
            exp_busy = '0;
            for (int i = 0; i < sb.size(); i++) exp_busy[sb[i].a] = 1'b1;
            if (wr_strobe) exp_busy[held_addr] = 1'b1;
            check("busy_mask", 32'(busy_mask), 32'(exp_busy));
            check("es_ready", 32'(es_ready), 32'(sb.size() < 4));
            check("ds_ready", 32'(ds_ready), 32'((sb.size() < 4) && !(es_req && sb.size() == 3)));
            if (sb.size() == 4) saw_full++;
            if (sb.size() == 3 && es_req && ds_req) saw_es_only = 1;

            if (es_req && es_ready) begin
                sb.push_back('{a: es_addr, d: es_data});
                exp_bank[es_addr] = es_data;
            end
            if (ds_req && ds_ready) begin
                sb.push_back('{a: ds_addr, d: ds_data});
                exp_bank[ds_addr] = ds_data;
            end
        end
    end

    // Holds each request until accepted; called just after a rising edge.
    task automatic send(input bit use_es, input logic [3:0] ea, input logic [31:0] ed,
                        input bit use_ds, input logic [3:0] da, input logic [31:0] dd);
        bit e_acc, d_acc;
        es_req = use_es; es_addr = ea; es_data = ed;
        ds_req = use_ds; ds_addr = da; ds_data = dd;
        for (int c = 0; c < 50 && (es_req || ds_req); c++) begin
            @(negedge clk);
            e_acc = es_req && es_ready;
            d_acc = ds_req && ds_ready;
            @(posedge clk); #1;
            if (e_acc) es_req = 1'b0;
            if (d_acc) ds_req = 1'b0;
        end
        if (es_req || ds_req) begin
            check("send_timeout", 32'd1, 32'd0);
            es_req = 1'b0;
            ds_req = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (count == 0 && !wr_strobe && busy_mask == 16'h0) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            bank[i]     = '0;
            exp_bank[i] = '0;
        end
        rst_n  = 1'b0;
        es_req = 1'b0; es_addr = '0; es_data = '0;
        ds_req = 1'b0; ds_addr = '0; ds_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", wr_data, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy_mask), 32'd0);
        check("rst_es_ready", 32'(es_ready), 32'd1);
        check("rst_ds_ready", 32'(ds_ready), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ES write r5 <= DEADBEEF: accepted at edge N.
        es_req = 1'b1; es_addr = 4'd5; es_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        es_req = 1'b0;
        check("t1_n0_busy", 32'(busy_mask), 32'h0020);
        check("t1_n0_strobe", 32'(wr_strobe), 32'd0);
        @(posedge clk); #1;
        check("t1_n1_addr", 32'(wr_addr), 32'd5);
        check("t1_n1_data", wr_data, 32'hDEADBEEF);
        check("t1_n1_strobe", 32'(wr_strobe), 32'd0);
        check("t1_n1_busy", 32'(busy_mask), 32'h0020);
        @(posedge clk); #1;
        check("t1_n2_strobe", 32'(wr_strobe), 32'd1);
        check("t1_n2_busy", 32'(busy_mask), 32'h0020);
        @(posedge clk); #1;
        check("t1_n3_strobe", 32'(wr_strobe), 32'd0);
        check("t1_n3_busy", 32'(busy_mask), 32'h0000);
        wait_idle();

        // Same-cycle ES/DS to r3: ES is older, so DS value wins.
        send(1'b1, 4'd3, 32'h11, 1'b1, 4'd3, 32'h22);
        wait_idle();
        check("t2_bank_r3", bank[3], 32'h22);

        // Six back-to-back ES writes: fills the FIFO, issues every 2 cycles.
        rise_cyc.delete();
        saw_full = 0;
        for (int k = 0; k < 6; k++) send(1'b1, 4'(k + 6), 32'hA000_0000 + 32'(k), 1'b0, '0, '0);
        wait_idle();
        check("t3_strobes", 32'(rise_cyc.size()), 32'd6);
        for (int i = 1; i < rise_cyc.size(); i++) check("t3_spacing", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd2);
        check("t3_saw_full", 32'(saw_full > 0), 32'd1);

        // Paired requests saturate the FIFO and hit the one-slot-left case.
        saw_es_only = 0;
        for (int k = 0; k < 5; k++) send(1'b1, 4'(k), 32'hE000_0000 + 32'(k), 1'b1, 4'(k + 8), 32'hD000_0000 + 32'(k));
        wait_idle();
        check("t4_es_only_case", 32'(saw_es_only), 32'd1);

        // r1, r2, r1: bit 1 stays busy until the second r1 strobe completes.
        r1_strobes = 0;
        send(1'b1, 4'd1, 32'h101, 1'b0, '0, '0);
        send(1'b1, 4'd2, 32'h202, 1'b0, '0, '0);
        send(1'b1, 4'd1, 32'h103, 1'b0, '0, '0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (!busy_mask[1]) break;
        end
        check("t6_busy1_clear", 32'(busy_mask[1]), 32'd0);
        check("t6_r1_strobes", 32'(r1_strobes), 32'd2);
        check("t6_strobe_low", 32'(wr_strobe), 32'd0);
        wait_idle();
        check("t6_bank_r1", bank[1], 32'h103);

        // Random mix of single and paired requests with idle gaps.
        for (int k = 0; k < 30; k++) begin
            int sel;
            sel = $urandom_range(2, 0);
            send(sel != 1, 4'($urandom_range(15, 0)), $urandom,
                 sel != 0, 4'($urandom_range(15, 0)), $urandom);
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
        for (int i = 0; i < 16; i++) check($sformatf("bank_r%0d", i), bank[i], exp_bank[i]);

        // Reset during PULSE with two entries queued.
        send(1'b1, 4'd7, 32'h7777, 1'b0, '0, '0);
        send(1'b1, 4'd8, 32'h8888, 1'b0, '0, '0);
        send(1'b1, 4'd9, 32'h9999, 1'b0, '0, '0);
        check("t5_pre_strobe", 32'(wr_strobe), 32'd1);
        check("t5_pre_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_strobe_drop", 32'(wr_strobe), 32'd0);
        check("t5_count_clr", 32'(count), 32'd0);
        check("t5_busy_clr", 32'(busy_mask), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        begin
            int base;
            base = rises;
            repeat (20) @(posedge clk);
            #1;
            check("t5_no_strobes", 32'(rises - base), 32'd0);
            check("t5_count_idle", 32'(count), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank_write_scheduler.md
# regbank_write_scheduler

Write-side front end for the 16×32 register bank. Accepts register writeback requests from the decode and execute stages, orders and buffers them in a small FIFO, and replays them to the bank's edge-triggered write port as clean setup-then-strobe sequences. Exports a pending-write mask so the decode stage can stall on read-after-write hazards.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `DATA_W`, 32: register data width.
- `ADDR_W`, 4: register address width (16 registers).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `es_req`  in  1  execute-stage write request.
- `es_addr`  in  ADDR_W  execute-stage target register.
- `es_data`  in  DATA_W  execute-stage write value.
- `es_ready`  out  1  execute request accepted when `es_req && es_ready`.
- `ds_req`  in  1  decode-stage write request.
- `ds_addr`  in  ADDR_W  decode-stage target register.
- `ds_data`  in  DATA_W  decode-stage write value.
- `ds_ready`  out  1  decode request accepted when `ds_req && ds_ready`.
- `wr_strobe`  out  1  to bank write-enable; bank writes on its rising edge.
- `wr_addr`  out  ADDR_W  to bank write address.
- `wr_data`  out  DATA_W  to bank write value.
- `busy_mask`  out  16  bit r set while any write to register r is queued or in flight.
- `count`  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Accept: `es_ready = count < DEPTH`. `ds_ready = count < DEPTH && !(es_req && count == DEPTH-1)`. Both are combinational.
- Simultaneous accept: the ES entry is pushed first, then the DS entry. ES holds the older instruction.
- A request while ready is low is ignored. The producer holds `req`, `addr`, and `data` until accepted.
- Issue FSM has three states: IDLE, SETUP, PULSE.
  - IDLE: if `count > 0`, load the FIFO head into `wr_addr`/`wr_data` and go to SETUP. `wr_strobe` = 0.
  - SETUP: `wr_strobe` → 1 and pop the head. Go to PULSE.
  - PULSE: `wr_strobe` → 0. If the FIFO is non-empty, load the new head into `wr_addr`/`wr_data` and go to SETUP; otherwise go to IDLE.
  - `wr_addr`/`wr_data` never change while `wr_strobe` is 1. Each write therefore produces exactly one rising edge with stable address and data.
- Order: writes reach the bank in acceptance order, including repeated writes to the same register; the last one wins.
- `busy_mask`: combinational OR of one-hot(`addr`) over all valid FIFO entries, plus the held entry while in SETUP or PULSE.
- No bypass: a request accepted into an empty FIFO always passes through the FIFO.
- No special register: address 0 is written like any other.

## Timing
- Reset values: `wr_strobe` 0, `wr_addr` 0, `wr_data` 0, `count` 0, `busy_mask` 0, state IDLE, FIFO pointers 0. `es_ready` and `ds_ready` are 1 after reset.
- Reset mid-operation clears everything asynchronously. A strobe in progress drops immediately, and queued writes are discarded.
- Latency, empty and IDLE:
  - Request accepted at edge N.
  - Edge N+1: address and data driven (SETUP).
  - Edge N+2: `wr_strobe` rises.
  - Edge N+3: `wr_strobe` falls.
- Busy timing:
  - `busy_mask` bit rises in the cycle after edge N.
  - It clears after edge N+3, unless another queued entry targets the same register.
- Throughput: one bank write per 2 cycles sustained.
- Push and pop in the same cycle: `count` changes by (pushes − pops). A pop at the SETUP→PULSE edge frees a slot that `ready` reflects in the next cycle.
- Full: with `count == DEPTH`, both readies are 0. When `count == DEPTH-1` and both stages request, only ES is accepted.

## Structure
- Shared package `regbank_pkg`:
  - `ADDR_W`, `DATA_W`, `NUM_REGS = 16`.
  - Typedef `wb_entry_t` {addr, data}.
  - Enum `wb_state_t` {IDLE, SETUP, PULSE}.
- Sub-module `wb_fifo`:
  - Synchronous FIFO of `wb_entry_t`.
  - Two push ports in priority order and one pop.
  - Head peek.
  - Exposes per-entry valid and address vectors for `busy_mask`.
- Top level contains the FSM, the output registers, and the ready logic.

## Test plan
- Single ES write (r5 ← 0xDEADBEEF) from idle:
  - `wr_addr`=5 and `wr_data`=0xDEADBEEF at N+1.
  - `wr_strobe` high only during cycle N+2.
  - `busy_mask`=0x0020 from N+1 to N+3.
- Same-cycle ES (r3 ← 0x11) and DS (r3 ← 0x22): two strobes in order 0x11 then 0x22, and the bank ends with r3 = 0x22.
- Hold `es_req` for 6 cycles with distinct data, DEPTH=4:
  - `es_ready` drops when `count` reaches 4.
  - All 6 writes are issued in order, two cycles apart.
- `count == 3` with both requesting: ES accepted, `ds_ready` = 0; DS is accepted in a following cycle once a slot frees.
- Assert `rst_n` low during PULSE with 2 entries queued:
  - `wr_strobe` drops immediately.
  - `count` and `busy_mask` go to 0.
  - No further strobes occur after release.
- Writes to r1, r2, r1: `busy_mask` bit 1 stays set until the second r1 strobe falls.
